wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width.
REQ-002 SHALL have parameter REG_N, default 32, number of architectural registers; address width 5.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port WB_i, input, 2, writeback controls: bit0 = RegWrite, bit1 = MemtoReg.
REQ-006 SHALL have port MemData_i, input, DATA_W, load data from the MEM/WB stage.
REQ-007 SHALL have port RegData_i, input, DATA_W, ALU result from the MEM/WB stage.
REQ-008 SHALL have port RegAddr_i, input, 5, destination register.
REQ-009 SHALL have ports RSaddr_i and RTaddr_i, input, 5 each, decode-stage read addresses.
REQ-010 SHALL have ports RSdata_o and RTdata_o, output, DATA_W each, read data.
REQ-011 SHALL have port WBData_o, output, DATA_W, selected writeback value, for EX forwarding.
REQ-012 SHALL have port WBValid_o, output, 1, high when a write to a nonzero register is in progress this cycle.
REQ-013 SHALL have port RetireCnt_o, output, 32, count of committed register writes.

Function
REQ-014 SHALL compute WBData_o combinationally: MemData_i when WB_i[1]=1, else RegData_i.
REQ-015 SHALL assert WBValid_o only when WB_i[0]=1 and RegAddr_i!=0, gated by rst_n_i=1.
REQ-016 SHALL write WBData_o into register RegAddr_i on the rising clk_i edge when WBValid_o=1.
REQ-017 SHALL hold register 0 at zero permanently; writes to it are dropped and not counted.
REQ-018 SHALL produce read data combinationally, with zero added cycles of latency.
REQ-019 SHALL bypass same-cycle writes: if WBValid_o=1 and a read address equals RegAddr_i, that port returns WBData_o instead of the stored value.
REQ-020 SHALL return zero on a read of address 0 regardless of bypass.
REQ-021 SHALL support both read ports hitting the bypass simultaneously, each independently.
REQ-022 SHALL increment RetireCnt_o by 1 on each edge with WBValid_o=1.
REQ-023 SHALL wrap RetireCnt_o from 0xFFFFFFFF to 0 silently.
REQ-024 SHALL apply the last write to an address on consecutive writes to that address, with no ordering hazard.
REQ-025 SHALL treat X on WB_i as illegal; the bench flags it, and the design needs no recovery behaviour.

Reset
REQ-026 SHALL, while rst_n_i=0, force all REG_N registers to 0, RetireCnt_o to 0, WBValid_o to 0, and suppress writes.
REQ-027 SHALL drive RSdata_o and RTdata_o to 0 during reset, since bypass is gated by WBValid_o.
REQ-028 SHALL take reset effect immediately when asserted mid-operation, discarding that cycle's pending write.
REQ-029 SHALL accept the first write on the first rising edge after rst_n_i deasserts.

Structure
REQ-030 SHALL place the WB bit indices (REGWRITE_BIT=0, MEMTOREG_BIT=1), DATA_W, REG_N, and the address width in the shared pipeline package used by the pipeline-register blocks.
REQ-031 SHALL implement the writeback select as sub-module wb_mux (2:1, DATA_W); the storage array and bypass logic stay in wb_regfile.
REQ-032 SHALL contain no latches; the storage array is flops with asynchronous clear.

Verification
REQ-033 SHALL verify reset: assert rst_n_i=0 mid-run after writing r5=0x1234 -> r5 reads 0 and RetireCnt_o=0 with no clock edge; both read ports read 0.
REQ-034 SHALL verify the writeback select: WB_i=2'b11, MemData_i=0xAAAA0000, RegData_i=0x5555, RegAddr_i=7, one edge -> r7=0xAAAA0000; with WB_i=2'b01 -> r7=0x5555.
REQ-035 SHALL verify bypass: WB_i=2'b01, RegAddr_i=9, RegData_i=0xDEADBEEF, RSaddr_i=RTaddr_i=9 before the edge -> both outputs read 0xDEADBEEF in the same cycle.
REQ-036 SHALL verify r0: WB_i=2'b01, RegAddr_i=0, RegData_i=0xFFFFFFFF -> RSaddr_i=0 reads 0, WBValid_o=0, RetireCnt_o unchanged.
REQ-037 SHALL verify counter wrap: force RetireCnt_o to 0xFFFFFFFE, then two valid writes -> 0xFFFFFFFF, then 0x00000000.
REQ-038 SHALL verify back-to-back writes: r3=1 then r3=2 on consecutive edges -> r3 reads 2, and RetireCnt_o rises by 2.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the MEM/WB writeback path and the register file.
// Holds writeback control bit positions, datapath widths and the write-qualify helper.
package wb_regfile_pkg;

  localparam int DATA_W       = 32;
  localparam int REG_N        = 32;
  localparam int ADDR_W       = 5;
  localparam int WB_W         = 2;
  localparam int CNT_W        = 32;
  localparam int REGWRITE_BIT = 0;
  localparam int MEMTOREG_BIT = 1;

  typedef logic [WB_W-1:0]   wb_ctrl_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // r0 is hardwired, so a RegWrite aimed at it is not a real commit.
  function automatic logic wb_writes(input wb_ctrl_t wb, input reg_addr_t addr);
    return wb[REGWRITE_BIT] && (addr != '0);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback/decode bundle between the MEM/WB stage, decode and the register file.
// Pure wiring; all signals are combinational with respect to the bundle.
interface wb_regfile_if #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
);
  import wb_regfile_pkg::*;

  wb_ctrl_t                 WB_i;
  logic [DATA_W-1:0]        MemData_i;
  logic [DATA_W-1:0]        RegData_i;
  reg_addr_t                RegAddr_i;
  reg_addr_t                RSaddr_i;
  reg_addr_t                RTaddr_i;
  logic [DATA_W-1:0]        RSdata_o;
  logic [DATA_W-1:0]        RTdata_o;
  logic [DATA_W-1:0]        WBData_o;
  logic                     WBValid_o;
  logic [CNT_W-1:0]         RetireCnt_o;

  modport slave (
    input  WB_i, MemData_i, RegData_i, RegAddr_i, RSaddr_i, RTaddr_i,
    output RSdata_o, RTdata_o, WBData_o, WBValid_o, RetireCnt_o
  );

  modport master (
    output WB_i, MemData_i, RegData_i, RegAddr_i, RSaddr_i, RTaddr_i,
    input  RSdata_o, RTdata_o, WBData_o, WBValid_o, RetireCnt_o
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Writeback value select: load data when MemtoReg, otherwise the ALU result.
// Purely combinational, zero latency, no flow control.
module wb_mux #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/wb_regfile.sv
// Two-read/one-write register file with same-cycle write bypass and a retire counter.
// Reads are combinational (zero latency); writes commit on the rising edge; no backpressure.
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int REG_N  = wb_regfile_pkg::REG_N
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  wb_regfile_if.slave  bus
);
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] wb_dat;
  logic              wb_vld;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;

  logic [DATA_W-1:0] rs_dat;
  logic [DATA_W-1:0] rt_dat;

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .sel_i (bus.WB_i[MEMTOREG_BIT]),
    .d0_i  (bus.RegData_i),
    .d1_i  (bus.MemData_i),
    .y_o   (wb_dat)
  );

  // Gating with reset keeps both the bypass and the counter quiet while held in reset.
  assign wb_vld = rst_n_i & wb_writes(bus.WB_i, bus.RegAddr_i);

  always_comb begin
    regs_d = regs_q;
    if (wb_vld) begin
      regs_d[bus.RegAddr_i] = wb_dat;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (wb_vld) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Each port bypasses independently; address 0 wins over any bypass match.
  always_comb begin
    rs_dat = regs_q[bus.RSaddr_i];
    if (wb_vld && (bus.RSaddr_i == bus.RegAddr_i)) begin
      rs_dat = wb_dat;
    end
    if (bus.RSaddr_i == '0) begin
      rs_dat = '0;
    end
  end

  always_comb begin
    rt_dat = regs_q[bus.RTaddr_i];
    if (wb_vld && (bus.RTaddr_i == bus.RegAddr_i)) begin
      rt_dat = wb_dat;
    end
    if (bus.RTaddr_i == '0) begin
      rt_dat = '0;
    end
  end

  assign bus.RSdata_o    = rs_dat;
  assign bus.RTdata_o    = rt_dat;
  assign bus.WBData_o    = wb_dat;
  assign bus.WBValid_o   = wb_vld;
  assign bus.RetireCnt_o = retire_cnt_q;

endmodule
